// File: rtl/gif_frame_sequencer.sv
// Frame sequencer: synchronizes the frame-rate tick, defers each advance to vertical blanking,
// and tracks the current frame index plus its base address in frame memory.
module gif_frame_sequencer #(
    parameter int NUM_FRAMES  = 8,
    parameter int IDX_W       = 3,
    parameter int FRAME_WORDS = 19200,
    parameter int ADDR_W      = 18,
    parameter int OVR_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_in,
    input  logic              en,
    input  logic              vblank,
    input  logic [1:0]        mode,
    input  logic              restart,
    output logic [IDX_W-1:0]  frame_idx,
    output logic [ADDR_W-1:0] frame_base,
    output logic              frame_start,
    output logic              done,
    output logic [OVR_W-1:0]  overrun
);
    localparam logic [IDX_W-1:0]  LAST = IDX_W'(NUM_FRAMES - 1);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(FRAME_WORDS);
    localparam logic [1:0] MODE_PING = 2'b01;
    localparam logic [1:0] MODE_ONE  = 2'b10;

    // sync_reg[0..1] form the synchronizer; sync_reg[2] holds the previous synchronized level
    logic [2:0]        sync_reg;
    logic              tick_reg;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [ADDR_W-1:0] base_reg, base_next;
    logic              dir_reg, dir_next;
    logic              done_reg, done_next;
    logic              pending_reg, pending_next;
    logic              start_reg, start_next;
    logic [OVR_W-1:0]  overrun_reg, overrun_next;

    always_comb begin
        idx_next     = idx_reg;
        base_next    = base_reg;
        dir_next     = dir_reg;
        done_next    = done_reg;
        pending_next = pending_reg;
        overrun_next = overrun_reg;
        start_next   = 1'b0;
        if (restart) begin
            idx_next     = '0;
            base_next    = '0;
            dir_next     = 1'b0;
            done_next    = 1'b0;
            pending_next = 1'b0;
            start_next   = 1'b1;
        end else if (!en) begin
            pending_next = 1'b0;
        end else if (pending_reg && vblank) begin
            start_next = 1'b1;
            if (NUM_FRAMES == 1) begin
                dir_next = 1'b0;
                if (mode == MODE_ONE) done_next = 1'b1;
            end else if (mode == MODE_PING) begin
                if (!dir_reg && idx_reg == LAST) begin
                    dir_next  = 1'b1;
                    idx_next  = idx_reg - 1'b1;
                    base_next = base_reg - STEP;
                end else if (dir_reg && idx_reg == '0) begin
                    dir_next  = 1'b0;
                    idx_next  = idx_reg + 1'b1;
                    base_next = base_reg + STEP;
                end else if (dir_reg) begin
                    idx_next  = idx_reg - 1'b1;
                    base_next = base_reg - STEP;
                end else begin
                    idx_next  = idx_reg + 1'b1;
                    base_next = base_reg + STEP;
                end
            end else if (mode == MODE_ONE) begin
                dir_next = 1'b0;
                if (idx_reg == LAST) begin
                    // already on the last frame: suppress the advance and just finish
                    done_next  = 1'b1;
                    start_next = 1'b0;
                end else begin
                    idx_next  = idx_reg + 1'b1;
                    base_next = base_reg + STEP;
                    if (idx_reg == LAST - 1'b1) done_next = 1'b1;
                end
            end else begin
                dir_next = 1'b0;
                if (idx_reg == LAST) begin
                    idx_next  = '0;
                    base_next = '0;
                end else begin
                    idx_next  = idx_reg + 1'b1;
                    base_next = base_reg + STEP;
                end
            end
            pending_next = tick_reg & ~done_next;
        end else if (tick_reg && !done_reg) begin
            if (pending_reg) begin
                if (overrun_reg != '1) overrun_next = overrun_reg + 1'b1;
            end else begin
                pending_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg    <= '0;
            tick_reg    <= 1'b0;
            idx_reg     <= '0;
            base_reg    <= '0;
            dir_reg     <= 1'b0;
            done_reg    <= 1'b0;
            pending_reg <= 1'b0;
            start_reg   <= 1'b0;
            overrun_reg <= '0;
        end else begin
            sync_reg    <= {sync_reg[1:0], tick_in};
            tick_reg    <= sync_reg[1] & ~sync_reg[2];
            idx_reg     <= idx_next;
            base_reg    <= base_next;
            dir_reg     <= dir_next;
            done_reg    <= done_next;
            pending_reg <= pending_next;
            start_reg   <= start_next;
            overrun_reg <= overrun_next;
        end
    end

    assign frame_idx   = idx_reg;
    assign frame_base  = base_reg;
    assign frame_start = start_reg;
    assign done        = done_reg;
    assign overrun     = overrun_reg;
endmodule
